// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit. It sits after the register file read
// ports and feeds the writeback path (WriteData/WriteRegister/RegWrite).
// Every operation takes a fixed 34 cycles:
//   accept edge k (IDLE) -> 32 iterations (RUN) -> result registered at k+33 (FINISH)
//
// Handshake: Start is sampled only while Busy=0. A rising edge with Start=1 in
// IDLE accepts the request and captures Funct3, Rd and both operands; Start
// while Busy=1 is ignored without side effects. Done is a single-cycle pulse
// that rises on the same edge Busy falls. Result/RdOut are valid while Done=1
// and hold until they are next overwritten. A Start held high during the Done
// cycle is accepted on the following edge.
//
// Ports:
//   CLK       in   1     rising-edge clock
//   RESET_N   in   1     asynchronous active-low reset
//   Start     in   1     request strobe
//   Funct3    in   3     000 MUL 001 MULH 010 MULHSU 011 MULHU
//                        100 DIV 101 DIVU 110 REM 111 REMU
//   OperandA  in   XLEN  rs1 (multiplicand / dividend)
//   OperandB  in   XLEN  rs2 (multiplier / divisor)
//   Rd        in   5     destination register index
//   Busy      out  1     operation in progress
//   Done      out  1     one-cycle completion pulse
//   Result    out  XLEN  result word
//   RdOut     out  5     Rd captured at accept
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] OperandA,
    input  logic [XLEN-1:0] OperandB,
    input  logic [4:0]      Rd,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic [4:0]      RdOut
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     a_q, a_d;        // |A|: multiplicand or dividend magnitude
    logic [XLEN-1:0]     b_q, b_d;        // |B|: divisor magnitude (mult. lives in acc)
    logic [2*XLEN-1:0]   acc_q, acc_d;    // product, or quotient in the low word
    logic [XLEN-1:0]     rem_q, rem_d;    // partial remainder
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                a_neg_q, a_neg_d;
    logic                b_neg_q, b_neg_d;
    logic                div0_q, div0_d;
    logic                ovf_q, ovf_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rd_q, rd_d;
    logic                done_q, done_d;

    // Operand conditioning at accept
    logic                a_signed_in, b_signed_in;
    logic                a_neg_in, b_neg_in;
    logic [XLEN-1:0]     a_mag_in, b_mag_in;

    // Iteration datapath
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_diff;
    logic                div_ge;

    // Sign-corrected results
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     dividend_raw;

    always_comb begin
        a_signed_in = (Funct3 == F_MULH) || (Funct3 == F_MULHSU) ||
                      (Funct3 == F_DIV)  || (Funct3 == F_REM);
        b_signed_in = (Funct3 == F_MULH) || (Funct3 == F_DIV) || (Funct3 == F_REM);
        a_neg_in    = a_signed_in && OperandA[XLEN-1];
        b_neg_in    = b_signed_in && OperandB[XLEN-1];
        a_mag_in    = a_neg_in ? -OperandA : OperandA;
        b_mag_in    = b_neg_in ? -OperandB : OperandB;

        // Shift-add: the multiplier sits in the low word and is shifted out
        // as the partial product shifts in from the top.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);

        // Restoring step over the 33-bit shifted remainder. The remainder is
        // always below the divisor, so the shifted value is below 2*divisor
        // and bit XLEN of the difference is a clean borrow flag.
        div_diff = {rem_q, acc_q[XLEN-1]} - {1'b0, b_q};
        div_ge   = ~div_diff[XLEN];

        prod_fix     = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quot_fix     = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix      = a_neg_q ? -rem_q : rem_q;
        dividend_raw = a_neg_q ? -a_q : a_q;
    end

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        rd_d     = rd_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    f3_d    = Funct3;
                    rd_d    = Rd;
                    a_d     = a_mag_in;
                    b_d     = b_mag_in;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    acc_d   = Funct3[2] ? {{XLEN{1'b0}}, a_mag_in}
                                        : {{XLEN{1'b0}}, b_mag_in};
                    rem_d   = '0;
                    cnt_d   = '0;
                    div0_d  = (OperandB == '0);
                    ovf_d   = ((Funct3 == F_DIV) || (Funct3 == F_REM)) &&
                              (OperandA == {1'b1, {(XLEN-1){1'b0}}}) &&
                              (OperandB == '1);
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (f3_q[2]) begin
                    rem_d = div_ge ? div_diff[XLEN-1:0] : {rem_q[XLEN-2:0], acc_q[XLEN-1]};
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                unique case (f3_q)
                    F_MUL:                     result_d = prod_fix[XLEN-1:0];
                    F_MULH, F_MULHSU, F_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                    F_DIV, F_DIVU: begin
                        if (div0_q)     result_d = '1;
                        else if (ovf_q) result_d = {1'b1, {(XLEN-1){1'b0}}};
                        else            result_d = quot_fix;
                    end
                    F_REM, F_REMU: begin
                        if (div0_q)     result_d = dividend_raw;
                        else if (ovf_q) result_d = '0;
                        else            result_d = rem_fix;
                    end
                    default:           result_d = '0;
                endcase
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            done_q   <= done_d;
        end
    end

    assign Busy   = (state_q != S_IDLE);
    assign Done   = done_q;
    assign Result = result_q;
    assign RdOut  = rd_q;

endmodule
